// File: rtl/dataflow_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dataflow_pkg                                                         |
// | Shared types and source/bus index constants for dataflow_fabric.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dataflow_pkg;

    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_DEC  = 2'b10,
        PC_LOAD = 2'b11
    } pc_op_e;

    localparam int BUS_ADL = 0;
    localparam int BUS_ADH = 1;
    localparam int BUS_DB  = 2;
    localparam int BUS_SB  = 3;

    // Source codes above the register file, relative to the register count.
    function automatic int src_din(input int num_regs);
        return num_regs;
    endfunction

    function automatic int src_pcl(input int num_regs);
        return num_regs + 1;
    endfunction

    function automatic int src_pch(input int num_regs);
        return num_regs + 2;
    endfunction

    function automatic int src_preset(input int num_regs);
        return num_regs + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dataflow_fabric_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dataflow_fabric_if                                                   |
// | Control word, memory-side and status signals of dataflow_fabric.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dataflow_fabric_if
    import dataflow_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REGS  = 8,
    parameter int NUM_BUSES = 4
);
    localparam int SRC_W = $clog2(NUM_REGS + 4);
    localparam int BUS_W = $clog2(NUM_BUSES);

    logic                          ctrl_valid;
    logic                          ctrl_ready;
    logic [NUM_BUSES*SRC_W-1:0]    bus_src;
    logic [NUM_BUSES*WIDTH-1:0]    bus_preset;
    logic [NUM_BUSES-2:0]          bridge_en;
    logic [NUM_REGS-1:0]           reg_ld;
    logic [NUM_REGS*BUS_W-1:0]     reg_bus;
    pc_op_e                        pc_op;
    logic                          addr_ld;
    logic                          dor_ld;
    logic                          flag_ld;
    logic [WIDTH-1:0]              din;
    logic                          din_valid;
    logic [2*WIDTH-1:0]            addr_out;
    logic [WIDTH-1:0]              dout;
    logic                          dout_valid;
    logic                          dout_ready;
    logic [2*WIDTH-1:0]            pc_out;
    logic                          flag_z;
    logic                          flag_n;

    modport master (
        output ctrl_valid, bus_src, bus_preset, bridge_en, reg_ld, reg_bus,
               pc_op, addr_ld, dor_ld, flag_ld, din, din_valid, dout_ready,
        input  ctrl_ready, addr_out, dout, dout_valid, pc_out, flag_z, flag_n
    );

    modport slave (
        input  ctrl_valid, bus_src, bus_preset, bridge_en, reg_ld, reg_bus,
               pc_op, addr_ld, dor_ld, flag_ld, din, din_valid, dout_ready,
        output ctrl_ready, addr_out, dout, dout_valid, pc_out, flag_z, flag_n
    );

endinterface
`default_nettype wire

// File: rtl/dataflow_fabric_pc_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_counter                                                           |
// | 2*WIDTH program counter with hold/inc/dec/load, resets to FF..00..   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_counter
    import dataflow_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_en,
    input  wire pc_op_e               i_op,
    input  wire logic [2*WIDTH-1:0]   i_load_val,
    output logic      [2*WIDTH-1:0]   o_pc
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= {{WIDTH{1'b1}}, {WIDTH{1'b0}}};
        end else if (i_en) begin
            case (i_op)
                PC_INC:  r_pc <= r_pc + PW'(1);
                PC_DEC:  r_pc <= r_pc - PW'(1);
                PC_LOAD: r_pc <= i_load_val;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/dataflow_fabric.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dataflow_fabric                                                      |
// | Register file on index-selected internal buses with PC, address,     |
// | din latch and handshaked dout. Optional flags: DATAFLOW_FLAGS_EN.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dataflow_fabric
    import dataflow_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REGS  = 8,
    parameter int NUM_BUSES = 4
) (
    input  wire logic        clk,
    input  wire logic        nrst,
    dataflow_fabric_if.slave bif
);
    localparam int SRC_W = $clog2(NUM_REGS + 4);
    localparam int BUS_W = $clog2(NUM_BUSES);

    logic [WIDTH-1:0]   r_regs    [NUM_REGS];
    logic [WIDTH-1:0]   w_reg_nxt [NUM_REGS];
    logic [WIDTH-1:0]   w_src     [NUM_BUSES];
    logic [WIDTH-1:0]   w_bus     [NUM_BUSES];
    logic [WIDTH-1:0]   r_din_latch;
    logic [2*WIDTH-1:0] r_addr;
    logic [WIDTH-1:0]   r_dout;
    logic               r_dout_valid;
    logic [2*WIDTH-1:0] w_pc;
    logic               w_accept;

    assign bif.ctrl_ready = nrst | ~r_dout_valid | bif.dout_ready;
    assign w_accept       = bif.ctrl_valid & bif.ctrl_ready;

    // Per-bus source decode, then bridges applied lowest index first so chains ripple upward.
    always_comb begin : p_bus_resolve
        logic [SRC_W-1:0] w_code;
        w_code = '0;
        for (int b = 0; b < NUM_BUSES; b++) begin
            w_code   = bif.bus_src[b*SRC_W +: SRC_W];
            w_src[b] = '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_code == SRC_W'(r)) w_src[b] = r_regs[r];
            end
            if (w_code == SRC_W'(src_din(NUM_REGS)))    w_src[b] = r_din_latch;
            if (w_code == SRC_W'(src_pcl(NUM_REGS)))    w_src[b] = w_pc[WIDTH-1:0];
            if (w_code == SRC_W'(src_pch(NUM_REGS)))    w_src[b] = w_pc[2*WIDTH-1:WIDTH];
            if (w_code == SRC_W'(src_preset(NUM_REGS))) w_src[b] = bif.bus_preset[b*WIDTH +: WIDTH];
        end
        w_bus[0] = w_src[0];
        for (int b = 1; b < NUM_BUSES; b++) begin
            w_bus[b] = bif.bridge_en[b-1] ? w_bus[b-1] : w_src[b];
        end
    end

    always_comb begin : p_reg_next
        for (int r = 0; r < NUM_REGS; r++) begin
            w_reg_nxt[r] = '0;
            for (int b = 0; b < NUM_BUSES; b++) begin
                if (bif.reg_bus[r*BUS_W +: BUS_W] == BUS_W'(b)) w_reg_nxt[r] = w_bus[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
        end else if (w_accept) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (bif.reg_ld[r]) r_regs[r] <= w_reg_nxt[r];
            end
        end
    end

    // The din latch runs off din_valid alone, not the control handshake.
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_din_latch <= '0;
        end else if (bif.din_valid) begin
            r_din_latch <= bif.din;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_addr       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_accept && bif.addr_ld) r_addr <= {w_bus[BUS_ADH], w_bus[BUS_ADL]};
            if (w_accept && bif.dor_ld) begin
                r_dout       <= w_bus[BUS_DB];
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && bif.dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    pc_counter #(
        .WIDTH      (WIDTH)
    ) u_pc (
        .clk        (clk),
        .rst        (nrst),
        .i_en       (w_accept),
        .i_op       (bif.pc_op),
        .i_load_val ({w_bus[BUS_ADH], w_bus[BUS_ADL]}),
        .o_pc       (w_pc)
    );

`ifdef DATAFLOW_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;

    always_ff @(posedge clk) begin
        if (nrst) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_accept && bif.flag_ld) begin
            r_flag_z <= (w_bus[BUS_DB] == '0);
            r_flag_n <= w_bus[BUS_DB][WIDTH-1];
        end
    end

    assign bif.flag_z = r_flag_z;
    assign bif.flag_n = r_flag_n;
`else
    logic w_unused_flag_ld;
    assign w_unused_flag_ld = bif.flag_ld;
    assign bif.flag_z       = 1'b0;
    assign bif.flag_n       = 1'b0;
`endif

    assign bif.addr_out   = r_addr;
    assign bif.dout       = r_dout;
    assign bif.dout_valid = r_dout_valid;
    assign bif.pc_out     = w_pc;

endmodule
`default_nettype wire

// File: tb/tb_dataflow_fabric.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dataflow_fabric                                                   |
// | Directed self-checking bench for dataflow_fabric.                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dataflow_fabric;
    import dataflow_pkg::*;

    localparam int WIDTH     = 8;
    localparam int NUM_REGS  = 8;
    localparam int NUM_BUSES = 4;
    localparam int SRC_W     = $clog2(NUM_REGS + 4);
    localparam int BUS_W     = $clog2(NUM_BUSES);
    localparam int C_PRESET  = NUM_REGS + 3;

    logic clk = 1'b0;
    logic nrst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dataflow_fabric_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .NUM_BUSES(NUM_BUSES)) bif ();

    dataflow_fabric #(
        .WIDTH     (WIDTH),
        .NUM_REGS  (NUM_REGS),
        .NUM_BUSES (NUM_BUSES)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bif  (bif.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_ctrl();
        bif.ctrl_valid = 1'b0;
        bif.bus_src    = '0;
        bif.bus_preset = '0;
        bif.bridge_en  = '0;
        bif.reg_ld     = '0;
        bif.reg_bus    = '0;
        bif.pc_op      = PC_HOLD;
        bif.addr_ld    = 1'b0;
        bif.dor_ld     = 1'b0;
        bif.flag_ld    = 1'b0;
    endtask

    task automatic set_src(input int b, input int code);
        bif.bus_src[b*SRC_W +: SRC_W] = SRC_W'(code);
    endtask

    task automatic set_preset(input int b, input logic [7:0] v);
        set_src(b, C_PRESET);
        bif.bus_preset[b*WIDTH +: WIDTH] = v;
    endtask

    task automatic set_ld(input int r, input int bsel);
        bif.reg_ld[r] = 1'b1;
        bif.reg_bus[r*BUS_W +: BUS_W] = BUS_W'(bsel);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue();
        bif.ctrl_valid = 1'b1;
        step();
        clear_ctrl();
    endtask

    // Observe a register through the address register: {00, reg[r]}.
    task automatic read_reg(input string tag, input int r, input logic [7:0] exp);
        set_src(BUS_ADL, r);
        set_preset(BUS_ADH, 8'h00);
        bif.addr_ld = 1'b1;
        issue();
        check(tag, 32'(bif.addr_out), {16'h0, 8'h00, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_fz_a, exp_fn_a, exp_fz_b;
`ifdef DATAFLOW_FLAGS_EN
        exp_fz_a = 1'b0; exp_fn_a = 1'b1; exp_fz_b = 1'b1;
`else
        exp_fz_a = 1'b0; exp_fn_a = 1'b0; exp_fz_b = 1'b0;
`endif
        nrst = 1'b1;
        clear_ctrl();
        bif.din        = '0;
        bif.din_valid  = 1'b0;
        bif.dout_ready = 1'b1;
        step();
        check("rdy_in_reset", 32'(bif.ctrl_ready), 32'h1);
        step();
        step();
        nrst = 1'b0;
        check("rst_pc", 32'(bif.pc_out), 32'hFF00);
        check("rst_addr", 32'(bif.addr_out), 32'h0);
        check("rst_dout", 32'(bif.dout), 32'h0);
        check("rst_dvalid", 32'(bif.dout_valid), 32'h0);
        check("rst_flags", {30'h0, bif.flag_z, bif.flag_n}, 32'h0);
        check("rst_ready", 32'(bif.ctrl_ready), 32'h1);

        // Preset on DB into reg3
        set_preset(BUS_DB, 8'h5A);
        set_ld(3, BUS_DB);
        issue();
        read_reg("reg3_preset", 3, 8'h5A);

        // Swap reg0/reg1 in a single word
        set_preset(BUS_SB, 8'h11);
        set_ld(0, BUS_SB);
        set_preset(BUS_DB, 8'h22);
        set_ld(1, BUS_DB);
        issue();
        set_src(BUS_ADL, 1);
        set_src(BUS_ADH, 0);
        set_ld(0, BUS_ADL);
        set_ld(1, BUS_ADH);
        issue();
        read_reg("swap_reg0", 0, 8'h22);
        read_reg("swap_reg1", 1, 8'h11);

        // PC load, wrap on increment and decrement
        set_preset(BUS_ADL, 8'hFF);
        set_preset(BUS_ADH, 8'hFF);
        bif.pc_op = PC_LOAD;
        issue();
        check("pc_load", 32'(bif.pc_out), 32'hFFFF);
        bif.pc_op = PC_INC;
        issue();
        check("pc_inc_wrap", 32'(bif.pc_out), 32'h0000);
        bif.pc_op = PC_DEC;
        issue();
        check("pc_dec_wrap", 32'(bif.pc_out), 32'hFFFF);
        bif.pc_op = PC_DEC;
        issue();
        check("pc_dec", 32'(bif.pc_out), 32'hFFFE);
        bif.pc_op = PC_INC;
        step();
        clear_ctrl();
        check("pc_no_valid", 32'(bif.pc_out), 32'hFFFE);

        // Chained bridge 0->1->2 overrides DB's own preset
        bif.bridge_en = 3'b011;
        set_preset(BUS_ADL, 8'h3C);
        set_src(BUS_ADH, 0);
        set_preset(BUS_DB, 8'h99);
        set_preset(BUS_SB, 8'h44);
        set_ld(2, BUS_DB);
        set_ld(6, BUS_SB);
        issue();
        read_reg("bridge_chain", 2, 8'h3C);
        read_reg("bridge_sb_own", 6, 8'h44);
        bif.bridge_en = 3'b100;
        set_preset(BUS_DB, 8'h77);
        set_preset(BUS_SB, 8'h55);
        set_ld(4, BUS_SB);
        issue();
        read_reg("bridge_db_sb", 4, 8'h77);

        // Output handshake: stall, then same-cycle consume and reload
        bif.dout_ready = 1'b0;
        set_preset(BUS_DB, 8'hA5);
        bif.dor_ld = 1'b1;
        issue();
        check("hs_dout1", 32'(bif.dout), 32'hA5);
        check("hs_valid1", 32'(bif.dout_valid), 32'h1);
        check("hs_rdy_low", 32'(bif.ctrl_ready), 32'h0);
        bif.ctrl_valid = 1'b1;
        set_preset(BUS_DB, 8'hC3);
        bif.dor_ld = 1'b1;
        bif.pc_op  = PC_INC;
        step();
        check("hs_stall_dout", 32'(bif.dout), 32'hA5);
        check("hs_stall_pc", 32'(bif.pc_out), 32'hFFFE);
        bif.dout_ready = 1'b1;
        #1;
        check("hs_rdy_comb", 32'(bif.ctrl_ready), 32'h1);
        step();
        clear_ctrl();
        check("hs_dout2", 32'(bif.dout), 32'hC3);
        check("hs_valid2", 32'(bif.dout_valid), 32'h1);
        check("hs_pc_once", 32'(bif.pc_out), 32'hFFFF);
        step();
        check("hs_consumed", 32'(bif.dout_valid), 32'h0);

        // din latch, PC halves and an undefined source code
        bif.din = 8'h6E;
        bif.din_valid = 1'b1;
        step();
        bif.din = 8'h00;
        bif.din_valid = 1'b0;
        set_src(BUS_DB, NUM_REGS);
        bif.dor_ld = 1'b1;
        issue();
        check("din_to_db", 32'(bif.dout), 32'h6E);
        set_src(BUS_ADL, NUM_REGS + 1);
        set_src(BUS_ADH, NUM_REGS + 2);
        bif.addr_ld = 1'b1;
        issue();
        check("addr_pc", 32'(bif.addr_out), 32'hFFFF);
        set_src(BUS_ADL, NUM_REGS + 4);
        set_preset(BUS_ADH, 8'h12);
        bif.addr_ld = 1'b1;
        issue();
        check("bad_src_zero", 32'(bif.addr_out), 32'h1200);

        // Flags from DB
        set_preset(BUS_DB, 8'h80);
        bif.flag_ld = 1'b1;
        issue();
        check("flag_n_80", 32'(bif.flag_n), 32'(exp_fn_a));
        check("flag_z_80", 32'(bif.flag_z), 32'(exp_fz_a));
        set_preset(BUS_DB, 8'h00);
        bif.flag_ld = 1'b1;
        issue();
        check("flag_z_00", 32'(bif.flag_z), 32'(exp_fz_b));
        check("flag_n_00", 32'(bif.flag_n), 32'h0);
        set_preset(BUS_DB, 8'h80);
        issue();
        check("flag_hold", 32'(bif.flag_z), 32'(exp_fz_b));

        // Reset in the middle of a pending output
        bif.dout_ready = 1'b0;
        set_preset(BUS_DB, 8'h05);
        bif.dor_ld = 1'b1;
        issue();
        check("mid_valid", 32'(bif.dout_valid), 32'h1);
        nrst = 1'b1;
        step();
        check("mid_rst_valid", 32'(bif.dout_valid), 32'h0);
        check("mid_rst_dout", 32'(bif.dout), 32'h0);
        check("mid_rst_pc", 32'(bif.pc_out), 32'hFF00);
        nrst = 1'b0;
        check("post_rst_rdy", 32'(bif.ctrl_ready), 32'h1);
        bif.dout_ready = 1'b1;
        read_reg("post_rst_reg3", 3, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dataflow_fabric.md
Name: dataflow_fabric

Overview:
- Parametrised successor to the fixed 8-bit CPU internal datapath: `NUM_REGS` general registers on `NUM_BUSES` index-selected internal buses.
- Also contains the program counter, the address output register, the input data latch and a handshaked data-output register.
- Driven each cycle by a control word from the logic controller. Sits between the controller and the external memory interface.

Parameters:
- WIDTH, 8: bit width of every register and bus.
- NUM_REGS, 8: number of general registers (2..16).
- NUM_BUSES, 4: number of internal buses (3..8).
  - Bus 0 = ADL, bus 1 = ADH, bus 2 = DB.
  - Higher indices are general (bus 3 = SB).
- Derived localparam SRC_W = $clog2(NUM_REGS+4).
- Derived localparam BUS_W = $clog2(NUM_BUSES).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  reset, synchronous, active-high (asserted = 1).
- ctrl_valid  in  1  control word present this cycle.
- ctrl_ready  out  1  control word accepted when ctrl_valid & ctrl_ready.
- bus_src  in  NUM_BUSES*SRC_W  per-bus source index.
- bus_preset  in  NUM_BUSES*WIDTH  per-bus preset constant.
- bridge_en  in  NUM_BUSES-1  bit b: bus b overrides bus b+1.
- reg_ld  in  NUM_REGS  per-register load enable.
- reg_bus  in  NUM_REGS*BUS_W  per-register source bus index.
- pc_op  in  2  00 hold, 01 inc, 10 dec, 11 load.
- addr_ld  in  1  load address output register.
- dor_ld  in  1  load data output register from DB.
- flag_ld  in  1  update flags (feature-gated).
- din  in  WIDTH  external read data.
- din_valid  in  1  capture din into input latch.
- addr_out  out  2*WIDTH  {ADH, ADL} address register.
- dout  out  WIDTH  data output register.
- dout_valid  out  1  dout holds unconsumed data.
- dout_ready  in  1  consumer accepts dout.
- pc_out  out  2*WIDTH  program counter.
- flag_z, flag_n  out  1 each  zero/negative of DB.

Behaviour:
- Source decode per bus (combinational): `bus_src` value
  - 0..NUM_REGS-1 selects reg[i];
  - NUM_REGS selects the din latch;
  - NUM_REGS+1 selects PC low;
  - NUM_REGS+2 selects PC high;
  - NUM_REGS+3 selects that bus's `bus_preset`;
  - any other code drives 0.
- Bridges resolve in ascending index order. If `bridge_en[b]`, bus b+1 takes the resolved value of bus b, so chains propagate (b→b+1→b+2).
- `ctrl_ready = ~dout_valid | dout_ready`. An accept is ctrl_valid & ctrl_ready. Without an accept, all control-driven state holds.
- On accept:
  - reg[r] <= bus[reg_bus[r]] where reg_ld[r]. An out-of-range bus index loads 0.
  - All loads sample pre-edge bus values, so a swap in one cycle is legal.
- PC on accept:
  - inc: PC+1, wraps FFFF→0000 (WIDTH=8).
  - dec: PC−1, wraps 0000→FFFF.
  - load: {bus1, bus0}.
- addr_ld on accept: addr_out <= {bus1, bus0}.
- Data output handshake:
  - dor_ld on accept: dout <= bus2 and dout_valid <= 1.
  - dout_valid clears when dout_valid & dout_ready & no new dor_ld accept.
  - Same-cycle consume + dor_ld: dout_valid stays 1 with the new data.
- din latch: din_latch <= din whenever din_valid, independent of ctrl_valid. Latch-to-bus latency is 1 cycle.
- Reset (nrst=1, overrides everything incl. mid-handshake):
  - all regs 0; PC = {WIDTH{1'b1}},{WIDTH{1'b0}} (FF00);
  - addr_out 0, dout 0, dout_valid 0, din_latch 0, flags 0.
- ctrl_ready is combinational; 1 during reset and the cycle after.

Optional Feature:
- Macro `DATAFLOW_FLAGS_EN`.
- Defined: on accept with flag_ld, flag_z <= (bus2 == 0) and flag_n <= bus2[WIDTH-1]. Otherwise the flags hold.
- Undefined: flag_z and flag_n tied 0, flag_ld ignored, no flag flops.

Decomposition:
- Package dataflow_pkg:
  - pc_op enum (PC_HOLD, PC_INC, PC_DEC, PC_LOAD);
  - bus index constants BUS_ADL=0, BUS_ADH=1, BUS_DB=2, BUS_SB=3;
  - source code offsets SRC_DIN, SRC_PCL, SRC_PCH, SRC_PRESET as functions of NUM_REGS.
- One sub-module, pc_counter: 2*WIDTH counter with hold/inc/dec/load and reset value.

Test Plan:
- Reset then bus_src[DB]=SRC_PRESET, preset 8'h5A, reg_ld[3]=1, reg_bus[3]=2 → reg3=5A next cycle; pc_out=FF00 after reset.
- reg0=11, reg1=22; one word loads reg0 from bus carrying reg1 and reg1 from bus carrying reg0 → reg0=22, reg1=11.
- PC load {bus1=FF, bus0=FF}, then pc_op=inc → pc_out=0000; then dec → FFFF.
- bridge_en=3'b011, bus0 sources preset 3C, reg_ld[2] from bus 2 → reg2=3C (chained bridge).
- dor_ld with dout_ready=0 → dout_valid=1, ctrl_ready=0, second word stalls with no reg change. Raise dout_ready → second word accepted same cycle, dout updated, dout_valid stays 1.
- `DATAFLOW_FLAGS_EN` defined, DB=80 flag_ld → flag_n=1, flag_z=0; DB=00 → flag_z=1. Undefined → both stay 0.
